// File: rtl/calc_pkg.sv
// Shared types and constants for the musical calculator sequencing logic.
package calc_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CONVERT = 3'd1,
    SOLVE   = 3'd2,
    PLAY    = 3'd3,
    HOLD    = 3'd4,
    CLEAR   = 3'd5
  } calc_state_t;

  localparam int TOKEN_W       = 32;
  localparam int DEFAULT_PTR_W = 6;

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter shared by the phase timeouts and the music duration.
// Loading N-1 on phase entry makes expired rise in the Nth cycle of the phase.
module phase_timer #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] loadValue,
  output logic         expired
);

  logic [W-1:0] count;

  // Reload on phase entry, otherwise count down and park at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= loadValue;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/calc_sequencer.sv
// Central sequencer: enter/clear strobes drive convert, solve, play, hold and clear phases.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int PTR_W          = DEFAULT_PTR_W,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int PLAY_CYCLES    = 50_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enter_key,
  input  logic               clear_key,
  input  logic [PTR_W-1:0]   infix_wptr,
  input  logic [PTR_W-1:0]   postfix_wptr,
  output logic               sy_start,
  input  logic               sy_done,
  output logic               solve_start,
  input  logic               solve_done,
  input  logic [TOKEN_W-1:0] answer_in,
  output logic [TOKEN_W-1:0] answer_out,
  output logic               answer_valid,
  output logic               solved,
  output logic               mem_clear,
  output logic               busy,
  output logic               error,
  output logic [2:0]         state_dbg
);

  localparam int TimerWRaw = $clog2(maxInt(TIMEOUT_CYCLES, PLAY_CYCLES));
  localparam int TimerW    = (TimerWRaw < 1) ? 1 : TimerWRaw;
  localparam logic [TimerW-1:0] TimeoutLoad = TimerW'(TIMEOUT_CYCLES - 1);
  localparam logic [TimerW-1:0] PlayLoad    = TimerW'(PLAY_CYCLES - 1);

  calc_state_t       state;
  calc_state_t       nextState;
  logic              enterPrev;
  logic              clearPrev;
  logic              keysPrimed;
  logic              enterEdge;
  logic              clearEdge;
  logic              restartPending;
  logic              nextRestart;
  logic              setError;
  logic              clrError;
  logic              latchAnswer;
  logic              timerLoad;
  logic [TimerW-1:0] timerValue;
  logic              timerExpired;

  phase_timer #(.W(TimerW)) uTimer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (timerLoad),
    .loadValue (timerValue),
    .expired   (timerExpired)
  );

  // Key edge detectors; keysPrimed masks the first cycle so a key held through reset is not an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enterPrev  <= 1'b0;
      clearPrev  <= 1'b0;
      keysPrimed <= 1'b0;
    end else begin
      enterPrev  <= enter_key;
      clearPrev  <= clear_key;
      keysPrimed <= 1'b1;
    end
  end

  assign enterEdge = keysPrimed & enter_key & ~enterPrev;
  assign clearEdge = keysPrimed & clear_key & ~clearPrev;

  // State register plus the "enter pressed in HOLD" restart request carried through CLEAR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      restartPending <= 1'b0;
    end else begin
      state          <= nextState;
      restartPending <= nextRestart;
    end
  end

  // Next-state and control decode; a clear edge overrides every other event
  always_comb begin
    nextState   = state;
    nextRestart = restartPending;
    setError    = 1'b0;
    clrError    = 1'b0;
    latchAnswer = 1'b0;
    timerLoad   = 1'b0;
    timerValue  = TimeoutLoad;
    if (clearEdge) begin
      nextState   = CLEAR;
      nextRestart = 1'b0;
      clrError    = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (enterEdge || restartPending) begin
            nextRestart = 1'b0;
            if (infix_wptr != '0) begin
              nextState = CONVERT;
              clrError  = 1'b1;
            end else begin
              setError = 1'b1;
            end
          end
        end
        CONVERT: begin
          if (sy_done) begin
            if (postfix_wptr != '0) begin
              nextState = SOLVE;
            end else begin
              nextState = CLEAR;
              setError  = 1'b1;
            end
          end else if (timerExpired) begin
            nextState = CLEAR;
            setError  = 1'b1;
          end
        end
        SOLVE: begin
          if (solve_done) begin
            nextState   = PLAY;
            latchAnswer = 1'b1;
          end else if (timerExpired) begin
            nextState = CLEAR;
            setError  = 1'b1;
          end
        end
        PLAY: begin
          if (timerExpired) begin
            nextState = HOLD;
          end
        end
        HOLD: begin
          if (enterEdge) begin
            nextState   = CLEAR;
            nextRestart = 1'b1;
          end
        end
        CLEAR: begin
          nextState = IDLE;
        end
        default: begin
          nextState = IDLE;
        end
      endcase
    end
    if ((nextState != state) &&
        (nextState == CONVERT || nextState == SOLVE || nextState == PLAY)) begin
      timerLoad  = 1'b1;
      timerValue = (nextState == PLAY) ? PlayLoad : TimeoutLoad;
    end
  end

  // Registered outputs derived from the upcoming state so they line up with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sy_start     <= 1'b0;
      solve_start  <= 1'b0;
      solved       <= 1'b0;
      mem_clear    <= 1'b0;
      busy         <= 1'b0;
      error        <= 1'b0;
      answer_out   <= '0;
      answer_valid <= 1'b0;
    end else begin
      sy_start    <= (nextState == CONVERT) && (state != CONVERT);
      solve_start <= (nextState == SOLVE) && (state != SOLVE);
      solved      <= (nextState == PLAY);
      mem_clear   <= (nextState == CLEAR);
      busy        <= (nextState != IDLE);
      if (setError) begin
        error <= 1'b1;
      end else if (clrError) begin
        error <= 1'b0;
      end
      if (latchAnswer) begin
        answer_out   <= answer_in;
        answer_valid <= 1'b1;
      end else if (nextState == CLEAR) begin
        answer_valid <= 1'b0;
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed vector bench for calc_sequencer with short timeout and play durations.
module tb_calc_sequencer;
  import calc_pkg::*;

  localparam int PtrW = 6;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            enter_key = 1'b0;
  logic            clear_key = 1'b0;
  logic [PtrW-1:0] infix_wptr = '0;
  logic [PtrW-1:0] postfix_wptr = '0;
  logic            sy_start;
  logic            sy_done = 1'b0;
  logic            solve_start;
  logic            solve_done = 1'b0;
  logic [31:0]     answer_in = '0;
  logic [31:0]     answer_out;
  logic            answer_valid;
  logic            solved;
  logic            mem_clear;
  logic            busy;
  logic            error;
  logic [2:0]      state_dbg;

  // flags order: {sy_start, solve_start, solved, mem_clear, busy, error, answer_valid}
  typedef struct {
    logic            enter;
    logic            clear;
    logic [PtrW-1:0] infix;
    logic [PtrW-1:0] postfix;
    logic            syDone;
    logic            solveDone;
    logic [31:0]     answerIn;
    calc_state_t     expState;
    logic [6:0]      expFlags;
    logic [31:0]     expAnswer;
  } vec_t;

  vec_t vecs[$];
  int   vectorCount = 0;
  int   missCount = 0;

  calc_sequencer #(
    .PTR_W          (PtrW),
    .TIMEOUT_CYCLES (16),
    .PLAY_CYCLES    (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enter_key    (enter_key),
    .clear_key    (clear_key),
    .infix_wptr   (infix_wptr),
    .postfix_wptr (postfix_wptr),
    .sy_start     (sy_start),
    .sy_done      (sy_done),
    .solve_start  (solve_start),
    .solve_done   (solve_done),
    .answer_in    (answer_in),
    .answer_out   (answer_out),
    .answer_valid (answer_valid),
    .solved       (solved),
    .mem_clear    (mem_clear),
    .busy         (busy),
    .error        (error),
    .state_dbg    (state_dbg)
  );

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic en, input logic cl, input int inf, input int post,
                              input logic syd, input logic sod, input int ans,
                              input calc_state_t st, input logic [6:0] flags, input int expAns);
    vec_t v;
    v.enter     = en;
    v.clear     = cl;
    v.infix     = PtrW'(inf);
    v.postfix   = PtrW'(post);
    v.syDone    = syd;
    v.solveDone = sod;
    v.answerIn  = 32'(ans);
    v.expState  = st;
    v.expFlags  = flags;
    v.expAnswer = 32'(expAns);
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    enter_key    = v.enter;
    clear_key    = v.clear;
    infix_wptr   = v.infix;
    postfix_wptr = v.postfix;
    sy_done      = v.syDone;
    solve_done   = v.solveDone;
    answer_in    = v.answerIn;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input calc_state_t st, input logic [6:0] flags,
                             input logic [31:0] ans);
    logic [6:0] got;
    got = {sy_start, solve_start, solved, mem_clear, busy, error, answer_valid};
    vectorCount++;
    if (state_dbg !== st || got !== flags || answer_out !== ans) begin
      missCount++;
      $display("[TB] FAIL %s: got state=%0d flags=%b answer=%0d, want state=%0d flags=%b answer=%0d",
               name, state_dbg, got, answer_out, st, flags, ans);
    end
  endtask

  task automatic runVec(input string name, input vec_t v);
    applyStimulus(v);
    checkOutput(name, v.expState, v.expFlags, v.expAnswer);
  endtask

  initial begin
    // normal run: sy_done 3 cycles after sy_start, solve_done 4 cycles after solve_start
    vecs.push_back(mk(1,0,5,5,0,0,0,  CONVERT,7'b1000100,0));
    vecs.push_back(mk(0,0,5,5,0,0,0,  CONVERT,7'b0000100,0));
    vecs.push_back(mk(0,0,5,5,0,0,0,  CONVERT,7'b0000100,0));
    vecs.push_back(mk(0,0,5,5,1,0,0,  SOLVE,  7'b0100100,0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0,0,5,5,0,0,0,SOLVE,7'b0000100,0));
    vecs.push_back(mk(0,0,5,5,0,1,42, PLAY,   7'b0010101,42));
    for (int i = 0; i < 7; i++) vecs.push_back(mk(0,0,5,5,0,0,0,PLAY,7'b0010101,42));
    vecs.push_back(mk(0,0,5,5,0,0,0,  HOLD,   7'b0000101,42));
    vecs.push_back(mk(0,1,5,5,0,0,0,  CLEAR,  7'b0001100,42));
    vecs.push_back(mk(0,0,5,5,0,0,0,  IDLE,   7'b0000000,42));
    // empty expression, then clear wipes the error
    vecs.push_back(mk(1,0,0,5,0,0,0,  IDLE,   7'b0000010,42));
    vecs.push_back(mk(0,0,0,5,0,0,0,  IDLE,   7'b0000010,42));
    vecs.push_back(mk(0,1,5,5,0,0,0,  CLEAR,  7'b0001100,42));
    vecs.push_back(mk(0,0,5,5,0,0,0,  IDLE,   7'b0000000,42));
    // stray done pulses in IDLE
    vecs.push_back(mk(0,0,5,5,1,0,0,  IDLE,   7'b0000000,42));
    vecs.push_back(mk(0,0,5,5,0,1,99, IDLE,   7'b0000000,42));
    // clear edge and sy_done together
    vecs.push_back(mk(1,0,5,5,0,0,0,  CONVERT,7'b1000100,42));
    vecs.push_back(mk(0,0,5,5,0,0,0,  CONVERT,7'b0000100,42));
    vecs.push_back(mk(0,1,5,5,1,0,0,  CLEAR,  7'b0001100,42));
    vecs.push_back(mk(0,0,5,5,0,0,0,  IDLE,   7'b0000000,42));
    vecs.push_back(mk(0,0,5,5,0,0,0,  IDLE,   7'b0000000,42));
    // empty postfix result
    vecs.push_back(mk(1,0,5,5,0,0,0,  CONVERT,7'b1000100,42));
    vecs.push_back(mk(0,0,5,0,1,0,0,  CLEAR,  7'b0001110,42));
    vecs.push_back(mk(0,0,5,5,0,0,0,  IDLE,   7'b0000010,42));
    // fast run to HOLD, then enter in HOLD restarts after CLEAR
    vecs.push_back(mk(1,0,5,5,0,0,0,  CONVERT,7'b1000100,42));
    vecs.push_back(mk(0,0,5,5,1,0,0,  SOLVE,  7'b0100100,42));
    vecs.push_back(mk(0,0,5,5,0,1,7,  PLAY,   7'b0010101,7));
    for (int i = 0; i < 7; i++) vecs.push_back(mk(0,0,5,5,0,0,0,PLAY,7'b0010101,7));
    vecs.push_back(mk(0,0,5,5,0,0,0,  HOLD,   7'b0000101,7));
    vecs.push_back(mk(1,0,5,5,0,0,0,  CLEAR,  7'b0001100,7));
    vecs.push_back(mk(0,0,5,5,0,0,0,  IDLE,   7'b0000000,7));
    vecs.push_back(mk(0,0,5,5,0,0,0,  CONVERT,7'b1000100,7));
    vecs.push_back(mk(0,1,5,5,0,0,0,  CLEAR,  7'b0001100,7));
    vecs.push_back(mk(0,0,5,5,0,0,0,  IDLE,   7'b0000000,7));

    // reset with enter held through release
    infix_wptr = 6'd5;
    enter_key  = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset state", IDLE, 7'b0000000, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("held key at release %0d", i), IDLE, 7'b0000000, 32'd0);
    end
    runVec("key released", mk(0,0,5,5,0,0,0,IDLE,7'b0000000,0));

    for (int i = 0; i < vecs.size(); i++) begin
      runVec($sformatf("vec %0d", i), vecs[i]);
    end

    // solver timeout with a stray enter during SOLVE
    runVec("timeout enter", mk(1,0,5,5,0,0,0,CONVERT,7'b1000100,7));
    runVec("timeout solve_start", mk(0,0,5,5,1,0,0,SOLVE,7'b0100100,7));
    for (int i = 2; i <= 16; i++) begin
      runVec($sformatf("solve cycle %0d", i), mk((i == 3),0,5,5,0,0,0,SOLVE,7'b0000100,7));
    end
    runVec("timeout clear", mk(0,0,5,5,0,0,0,CLEAR,7'b0001110,7));
    runVec("timeout idle", mk(0,0,5,5,0,0,0,IDLE,7'b0000010,7));

    // reset while solved is high
    runVec("pre-reset clear", mk(0,1,5,5,0,0,0,CLEAR,7'b0001100,7));
    runVec("pre-reset idle", mk(0,0,5,5,0,0,0,IDLE,7'b0000000,7));
    runVec("pre-reset convert", mk(1,0,5,5,0,0,0,CONVERT,7'b1000100,7));
    runVec("pre-reset solve", mk(0,0,5,5,1,0,0,SOLVE,7'b0100100,7));
    runVec("pre-reset play", mk(0,0,5,5,0,1,55,PLAY,7'b0010101,55));
    runVec("pre-reset play 2", mk(0,0,5,5,0,0,0,PLAY,7'b0010101,55));
    enter_key = 1'b1;
    rst_n     = 1'b0;
    #1;
    checkOutput("reset mid-PLAY", IDLE, 7'b0000000, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("after mid-run reset %0d", i), IDLE, 7'b0000000, 32'd0);
    end
    enter_key = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
